pic_control_logic: RTL and testbench
====================================

Name: pic_control_logic

Overview:
- Command/sequence controller of the 8259A model, directly upstream of the data bus buffer.
- Decodes ICW1-ICW4 and OCW1-OCW3 writes and tracks initialization state.
- Runs the INTA pulse sequence in both 8080 and 8086 modes.
- Drives the buffer's control_logic_data / out_control_logic_data / enable_read_register / read_register_isr_or_irr / interrupt_mask inputs.

Parameters:
- CALL_OPCODE, 8'hCD, first byte driven in the 8080 INTA sequence.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; all state cleared on the clock edge where reset=1
- write_strobe  in  1  one-cycle pulse per completed CS&WR write (already synchronized)
- address  in  1  A0 of the write
- data_bus_in  in  8  write data
- interrupt_acknowledge_n  in  1  synchronized INTA level, active-low
- highest_level_in_service  in  8  one-hot highest ISR bit, from the priority resolver
- interrupt_mask  out  8  OCW1 mask
- control_logic_data  out  8  byte for the buffer during INTA
- out_control_logic_data  out  1  buffer drives control_logic_data when 1
- enable_read_register  out  1  status reads allowed
- read_register_isr_or_irr  out  1  0=IRR, 1=ISR
- level_or_edge_triggered  out  1  ICW1 LTIM
- freeze  out  1  IRR latch hold during INTA
- latch_in_service  out  1  one-cycle pulse; ISR set request
- end_of_interrupt  out  8  one-hot, one-cycle EOI pulse
- initialized  out  1  ICW sequence complete

Behaviour:
- Reset:
  - every output 0, state=WAIT_ICW1, INTA counter 0.
  - ic4=0, single=0, upm=0, aeoi=0, icw1/icw2 regs 0.
- All outputs are registered. Effects appear on the clock after the write_strobe or INTA edge.
- ICW1 (strobe, A0=0, D4=1) is accepted in any state, including mid-INTA:
  - latch ltim=D3, single=D1, ic4=D0, icw1[7:5]=D7:5.
  - interrupt_mask=0, read_register_isr_or_irr=0, aeoi=0, upm=0.
  - abort any INTA sequence: counter=0, freeze=0, out_control_logic_data=0.
  - initialized=0, state=ICW2.
- ICW2 (A0=1): icw2=D. Next state: ICW3 if !single; else ICW4 if ic4; else READY.
- ICW3 (A0=1): stored, no other effect. Next state: ICW4 if ic4, else READY.
- ICW4 (A0=1): upm=D0, aeoi=D1. Next state: READY.
- In ICW2/3/4, writes with A0=0 and D4=0 are ignored; state is unchanged.
- READY: initialized=1 and enable_read_register=1, except enable_read_register=0 while an INTA sequence is active.
- OCW1 (READY, A0=1): interrupt_mask=D.
- OCW2 (READY, A0=0, D4:3=00), by D7:5:
  - 001: end_of_interrupt=highest_level_in_service.
  - 011: end_of_interrupt=1<<D2:0.
  - other codes: ignored.
- OCW3 (READY, A0=0, D4:3=01): if D1=1, read_register_isr_or_irr=D0; otherwise unchanged.
- Writes before READY, other than ICW1 and the expected ICW, are ignored.
- INTA is honoured only in READY.
  - Falling edge is detected against a registered copy of the input. Counter n increments on each falling edge.
- 8086 mode (upm=1):
  - Edge 1: freeze=1, latch_in_service pulse, nothing driven.
  - Edge 2: control_logic_data={icw2[7:3], enc(highest_level_in_service)}; out_control_logic_data=1 while INTA low.
  - Rising edge after pulse 2: out_control_logic_data=0, freeze=0, n=0; if aeoi, end_of_interrupt=level latched at edge 2.
- 8080 mode (upm=0):
  - Edge 1: freeze=1, latch_in_service pulse, data=CALL_OPCODE.
  - Edge 2: data={icw1[7:5], enc, 2'b00} (interval 4 only).
  - Edge 3: data=icw2.
  - out_control_logic_data=1 only while INTA is low in each pulse.
  - Completion after pulse 3 is the same as 8086 completion.
- If highest_level_in_service=0 at the vector edge, enc=3'd7 (spurious IR7).
- Simultaneous write_strobe and INTA edge: both are processed; an ICW1 write takes precedence and aborts the sequence.

Decomposition:
- Package pic_control_pkg:
  - init state enum {WAIT_ICW1, ICW2, ICW3, ICW4, READY}.
  - OCW2 command codes (NS_EOI=3'b001, SP_EOI=3'b011).
  - one-hot-to-binary encode function.
- One natural sub-module, pic_inta_sequencer: edge detect, pulse counter, byte mux, freeze/aeoi completion.

Test Plan:
- ICW1=8'h13, ICW2=8'h20, ICW4=8'h01 -> initialized=1 after the third write; interrupt_mask=0; upm=1.
- 8086: highest_level_in_service=8'h08, two INTA pulses -> latch_in_service on edge 1; control_logic_data=8'h23 with out_control_logic_data=1 during pulse 2 only; freeze returns to 0.
- 8080: ICW1=8'h12 (single, no IC4), ICW2=8'h40, level 8'h01 -> bytes 8'hCD, 8'h00, 8'h40 on pulses 1-3.
- OCW1=8'hF0 then OCW3=8'h0B -> interrupt_mask=8'hF0, read_register_isr_or_irr=1. OCW3=8'h08 -> value unchanged.
- OCW2=8'h20 with in-service 8'h04 -> end_of_interrupt=8'h04 for one cycle. OCW2=8'h65 -> 8'h20. AEOI set plus a completed 8086 sequence -> automatic pulse.
- ICW1 written after INTA pulse 1, and reset asserted mid-sequence -> freeze=0, out_control_logic_data=0, counter cleared; initialized=0.

Source files
------------

// File: rtl/pic_control_pkg.sv
// Shared types and helpers for the 8259A command/sequence controller.
package pic_control_pkg;

    typedef enum logic [2:0] {
        WAIT_ICW1,
        ICW2,
        ICW3,
        ICW4,
        READY
    } init_state_t;

    localparam logic [2:0] NS_EOI = 3'b001;
    localparam logic [2:0] SP_EOI = 3'b011;

    // One-hot to binary; an empty vector reports the spurious level IR7.
    function automatic logic [2:0] encode_level(input logic [7:0] level);
        logic [2:0] enc;
        enc = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (level[i]) enc = 3'(i);
        end
        return enc;
    endfunction

endpackage

// File: rtl/pic_control_logic_if.sv
// Bus between the control logic and its neighbours (write port, INTA, resolver, data buffer).
interface pic_control_logic_if;
    logic       write_strobe;
    logic       address;
    logic [7:0] data_bus_in;
    logic       interrupt_acknowledge_n;
    logic [7:0] highest_level_in_service;
    logic [7:0] interrupt_mask;
    logic [7:0] control_logic_data;
    logic       out_control_logic_data;
    logic       enable_read_register;
    logic       read_register_isr_or_irr;
    logic       level_or_edge_triggered;
    logic       freeze;
    logic       latch_in_service;
    logic [7:0] end_of_interrupt;
    logic       initialized;

    modport master (
        output write_strobe, address, data_bus_in, interrupt_acknowledge_n,
               highest_level_in_service,
        input  interrupt_mask, control_logic_data, out_control_logic_data,
               enable_read_register, read_register_isr_or_irr, level_or_edge_triggered,
               freeze, latch_in_service, end_of_interrupt, initialized
    );

    modport slave (
        input  write_strobe, address, data_bus_in, interrupt_acknowledge_n,
               highest_level_in_service,
        output interrupt_mask, control_logic_data, out_control_logic_data,
               enable_read_register, read_register_isr_or_irr, level_or_edge_triggered,
               freeze, latch_in_service, end_of_interrupt, initialized
    );
endinterface

// File: rtl/pic_inta_sequencer.sv
// INTA pulse sequencer: edge detect, pulse counter, vector byte mux and completion handling.
module pic_inta_sequencer
    import pic_control_pkg::*;
#(
    parameter logic [7:0] CALL_OPCODE = 8'hCD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       abort,
    input  logic       enable,
    input  logic       interrupt_acknowledge_n,
    input  logic [7:0] highest_level_in_service,
    input  logic       upm,
    input  logic       aeoi,
    input  logic [2:0] icw1_vector_bits,
    input  logic [7:0] icw2,
    output logic [7:0] control_logic_data,
    output logic       out_control_logic_data,
    output logic       freeze,
    output logic       latch_in_service,
    output logic       active_next,
    output logic [7:0] aeoi_eoi_next
);

    logic       inta_n_q;
    logic [1:0] count_q, count_d;
    logic [7:0] data_q, data_d;
    logic       out_q, out_d;
    logic       freeze_q, freeze_d;
    logic       lis_q, lis_d;
    logic [7:0] level_q, level_d;

    logic       fall, rise;
    logic [1:0] last_pulse;
    logic [2:0] enc;

    assign fall       = inta_n_q & ~interrupt_acknowledge_n;
    assign rise       = ~inta_n_q & interrupt_acknowledge_n;
    assign last_pulse = upm ? 2'd2 : 2'd3;
    assign enc        = encode_level(highest_level_in_service);

    always_comb begin
        count_d       = count_q;
        data_d        = data_q;
        out_d         = out_q;
        freeze_d      = freeze_q;
        lis_d         = 1'b0;
        level_d       = level_q;
        aeoi_eoi_next = 8'h00;

        if (abort) begin
            count_d  = 2'd0;
            data_d   = 8'h00;
            out_d    = 1'b0;
            freeze_d = 1'b0;
        end else if (enable) begin
            if (fall && count_q != last_pulse) begin
                count_d = count_q + 2'd1;
                out_d   = 1'b1;
                case (count_q)
                    2'd0: begin
                        freeze_d = 1'b1;
                        lis_d    = 1'b1;
                        // 8086 drives nothing on the first pulse.
                        out_d    = ~upm;
                        if (!upm) data_d = CALL_OPCODE;
                    end
                    2'd1: begin
                        level_d = highest_level_in_service;
                        data_d  = upm ? {icw2[7:3], enc} : {icw1_vector_bits, enc, 2'b00};
                    end
                    default: data_d = icw2;
                endcase
            end else if (rise) begin
                out_d = 1'b0;
                if (count_q == last_pulse) begin
                    count_d  = 2'd0;
                    freeze_d = 1'b0;
                    if (aeoi) aeoi_eoi_next = level_q;
                end
            end
        end
    end

    assign active_next = (count_d != 2'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            inta_n_q <= 1'b0;
            count_q  <= 2'd0;
            data_q   <= 8'h00;
            out_q    <= 1'b0;
            freeze_q <= 1'b0;
            lis_q    <= 1'b0;
            level_q  <= 8'h00;
        end else begin
            inta_n_q <= interrupt_acknowledge_n;
            count_q  <= count_d;
            data_q   <= data_d;
            out_q    <= out_d;
            freeze_q <= freeze_d;
            lis_q    <= lis_d;
            level_q  <= level_d;
        end
    end

    assign control_logic_data     = data_q;
    assign out_control_logic_data = out_q;
    assign freeze                 = freeze_q;
    assign latch_in_service       = lis_q;

endmodule

// File: rtl/pic_control_logic.sv
// 8259A command/sequence controller: ICW/OCW decode, init tracking, INTA sequencing.
module pic_control_logic
    import pic_control_pkg::*;
#(
    parameter logic [7:0] CALL_OPCODE = 8'hCD
) (
    input logic              clock,
    input logic              reset,
    pic_control_logic_if.slave bus
);

    init_state_t state_q, state_d;
    logic        single_q, single_d;
    logic        ic4_q, ic4_d;
    logic        ltim_q, ltim_d;
    logic [2:0]  icw1_bits_q, icw1_bits_d;
    logic [7:0]  icw2_q, icw2_d;
    logic        upm_q, upm_d;
    logic        aeoi_q, aeoi_d;
    logic [7:0]  mask_q, mask_d;
    logic        rr_q, rr_d;
    logic [7:0]  eoi_q, eoi_d;
    logic        init_q, init_d;
    logic        err_q, err_d;

    logic        icw1_write, data_write;
    logic [7:0]  ocw_eoi;
    logic        seq_active_next;
    logic [7:0]  seq_eoi_next;

    assign data_write = bus.write_strobe & bus.address;
    assign icw1_write = bus.write_strobe & ~bus.address & bus.data_bus_in[4];

    always_comb begin
        state_d     = state_q;
        single_d    = single_q;
        ic4_d       = ic4_q;
        ltim_d      = ltim_q;
        icw1_bits_d = icw1_bits_q;
        icw2_d      = icw2_q;
        upm_d       = upm_q;
        aeoi_d      = aeoi_q;
        mask_d      = mask_q;
        rr_d        = rr_q;
        ocw_eoi     = 8'h00;

        case (state_q)
            ICW2: if (data_write) begin
                icw2_d  = bus.data_bus_in;
                state_d = !single_q ? ICW3 : (ic4_q ? ICW4 : READY);
            end
            // Cascade configuration has no effect in this model, so it is not kept.
            ICW3: if (data_write) state_d = ic4_q ? ICW4 : READY;
            ICW4: if (data_write) begin
                upm_d   = bus.data_bus_in[0];
                aeoi_d  = bus.data_bus_in[1];
                state_d = READY;
            end
            READY: begin
                if (data_write) mask_d = bus.data_bus_in;
                if (bus.write_strobe && !bus.address) begin
                    if (bus.data_bus_in[4:3] == 2'b00) begin
                        case (bus.data_bus_in[7:5])
                            NS_EOI:  ocw_eoi = bus.highest_level_in_service;
                            SP_EOI:  ocw_eoi = 8'd1 << bus.data_bus_in[2:0];
                            default: ocw_eoi = 8'h00;
                        endcase
                    end else if (bus.data_bus_in[4:3] == 2'b01 && bus.data_bus_in[1]) begin
                        rr_d = bus.data_bus_in[0];
                    end
                end
            end
            default: ;
        endcase

        if (icw1_write) begin
            ltim_d      = bus.data_bus_in[3];
            single_d    = bus.data_bus_in[1];
            ic4_d       = bus.data_bus_in[0];
            icw1_bits_d = bus.data_bus_in[7:5];
            mask_d      = 8'h00;
            rr_d        = 1'b0;
            aeoi_d      = 1'b0;
            upm_d       = 1'b0;
            state_d     = ICW2;
        end

        init_d = (state_d == READY);
        err_d  = (state_d == READY) && !seq_active_next;
        eoi_d  = ocw_eoi | seq_eoi_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= WAIT_ICW1;
            single_q    <= 1'b0;
            ic4_q       <= 1'b0;
            ltim_q      <= 1'b0;
            icw1_bits_q <= 3'd0;
            icw2_q      <= 8'h00;
            upm_q       <= 1'b0;
            aeoi_q      <= 1'b0;
            mask_q      <= 8'h00;
            rr_q        <= 1'b0;
            eoi_q       <= 8'h00;
            init_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            single_q    <= single_d;
            ic4_q       <= ic4_d;
            ltim_q      <= ltim_d;
            icw1_bits_q <= icw1_bits_d;
            icw2_q      <= icw2_d;
            upm_q       <= upm_d;
            aeoi_q      <= aeoi_d;
            mask_q      <= mask_d;
            rr_q        <= rr_d;
            eoi_q       <= eoi_d;
            init_q      <= init_d;
            err_q       <= err_d;
        end
    end

    pic_inta_sequencer #(
        .CALL_OPCODE(CALL_OPCODE)
    ) u_inta_sequencer (
        .clock                    (clock),
        .reset                    (reset),
        .abort                    (icw1_write),
        .enable                   (state_q == READY),
        .interrupt_acknowledge_n  (bus.interrupt_acknowledge_n),
        .highest_level_in_service (bus.highest_level_in_service),
        .upm                      (upm_q),
        .aeoi                     (aeoi_q),
        .icw1_vector_bits         (icw1_bits_q),
        .icw2                     (icw2_q),
        .control_logic_data       (bus.control_logic_data),
        .out_control_logic_data   (bus.out_control_logic_data),
        .freeze                   (bus.freeze),
        .latch_in_service         (bus.latch_in_service),
        .active_next              (seq_active_next),
        .aeoi_eoi_next            (seq_eoi_next)
    );

    assign bus.interrupt_mask           = mask_q;
    assign bus.read_register_isr_or_irr = rr_q;
    assign bus.level_or_edge_triggered  = ltim_q;
    assign bus.end_of_interrupt         = eoi_q;
    assign bus.initialized              = init_q;
    assign bus.enable_read_register     = err_q;

endmodule

// File: tb/tb_pic_control_logic.sv
// Directed, table-driven bench for pic_control_logic plus hand-written INTA corner sequences.
module tb_pic_control_logic;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pic_control_logic_if bus ();

    pic_control_logic #(
        .CALL_OPCODE(8'hCD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        ws;
        logic        a0;
        logic [7:0]  d;
        logic        inta_n;
        logic [7:0]  hls;
        logic [30:0] want;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    vec_t tbl[31];

    // Expected-output packing: mask, cld, ocld, err, rr, ltim, freeze, lis, eoi, init.
    function automatic logic [30:0] E(input logic [7:0] mask, input logic [7:0] cld,
                                      input logic ocld, input logic err, input logic rr,
                                      input logic ltim, input logic frz, input logic lis,
                                      input logic [7:0] eoi, input logic init);
        return {mask, cld, ocld, err, rr, ltim, frz, lis, eoi, init};
    endfunction

    function automatic vec_t V(input logic ws, input logic a0, input logic [7:0] d,
                               input logic inta_n, input logic [7:0] hls,
                               input logic [30:0] want);
        vec_t v;
        v.ws = ws; v.a0 = a0; v.d = d; v.inta_n = inta_n; v.hls = hls; v.want = want;
        return v;
    endfunction

    function automatic logic [30:0] actual();
        return {bus.interrupt_mask, bus.control_logic_data, bus.out_control_logic_data,
                bus.enable_read_register, bus.read_register_isr_or_irr,
                bus.level_or_edge_triggered, bus.freeze, bus.latch_in_service,
                bus.end_of_interrupt, bus.initialized};
    endfunction

    task automatic check(input string name, input logic [30:0] want);
        logic [30:0] got;
        got = actual();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (mask,cld,ocld,err,rr,ltim,frz,lis,eoi,init)",
                     name, got, want);
        end
    endtask

    task automatic step(input logic ws, input logic a0, input logic [7:0] d,
                        input logic inta_n, input logic [7:0] hls);
        bus.write_strobe             = ws;
        bus.address                  = a0;
        bus.data_bus_in              = d;
        bus.interrupt_acknowledge_n  = inta_n;
        bus.highest_level_in_service = hls;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic inta_n, input string name);
        bus.write_strobe            = 1'b0;
        bus.interrupt_acknowledge_n = inta_n;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check(name, 31'h0);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = V(1, 0, 8'h13, 1, 8'h00, E(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        tbl[1]  = V(1, 1, 8'h20, 1, 8'h00, E(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        tbl[2]  = V(1, 1, 8'h01, 1, 8'h00, E(8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 1));
        tbl[3]  = V(0, 0, 8'h00, 1, 8'h00, E(8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 1));
        tbl[4]  = V(0, 0, 8'h00, 0, 8'h08, E(8'h00, 8'h00, 0, 0, 0, 0, 1, 1, 8'h00, 1));
        tbl[5]  = V(0, 0, 8'h00, 0, 8'h08, E(8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 1));
        tbl[6]  = V(0, 0, 8'h00, 1, 8'h08, E(8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 1));
        tbl[7]  = V(0, 0, 8'h00, 0, 8'h08, E(8'h00, 8'h23, 1, 0, 0, 0, 1, 0, 8'h00, 1));
        tbl[8]  = V(0, 0, 8'h00, 0, 8'h08, E(8'h00, 8'h23, 1, 0, 0, 0, 1, 0, 8'h00, 1));
        tbl[9]  = V(0, 0, 8'h00, 1, 8'h08, E(8'h00, 8'h23, 0, 1, 0, 0, 0, 0, 8'h00, 1));
        tbl[10] = V(1, 1, 8'hF0, 1, 8'h00, E(8'hF0, 8'h23, 0, 1, 0, 0, 0, 0, 8'h00, 1));
        tbl[11] = V(1, 0, 8'h0B, 1, 8'h00, E(8'hF0, 8'h23, 0, 1, 1, 0, 0, 0, 8'h00, 1));
        tbl[12] = V(1, 0, 8'h08, 1, 8'h00, E(8'hF0, 8'h23, 0, 1, 1, 0, 0, 0, 8'h00, 1));
        tbl[13] = V(1, 0, 8'h20, 1, 8'h04, E(8'hF0, 8'h23, 0, 1, 1, 0, 0, 0, 8'h04, 1));
        tbl[14] = V(0, 0, 8'h00, 1, 8'h04, E(8'hF0, 8'h23, 0, 1, 1, 0, 0, 0, 8'h00, 1));
        tbl[15] = V(1, 0, 8'h65, 1, 8'h00, E(8'hF0, 8'h23, 0, 1, 1, 0, 0, 0, 8'h20, 1));
        tbl[16] = V(0, 0, 8'h00, 1, 8'h00, E(8'hF0, 8'h23, 0, 1, 1, 0, 0, 0, 8'h00, 1));
        tbl[17] = V(1, 0, 8'h40, 1, 8'h04, E(8'hF0, 8'h23, 0, 1, 1, 0, 0, 0, 8'h00, 1));
        tbl[18] = V(1, 0, 8'h1B, 1, 8'h00, E(8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0));
        tbl[19] = V(1, 0, 8'h00, 1, 8'h00, E(8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0));
        tbl[20] = V(1, 1, 8'hA8, 1, 8'h00, E(8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0));
        tbl[21] = V(1, 1, 8'h03, 1, 8'h00, E(8'h00, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00, 1));
        tbl[22] = V(0, 0, 8'h00, 0, 8'h40, E(8'h00, 8'h00, 0, 0, 0, 1, 1, 1, 8'h00, 1));
        tbl[23] = V(0, 0, 8'h00, 1, 8'h40, E(8'h00, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 1));
        tbl[24] = V(0, 0, 8'h00, 0, 8'h40, E(8'h00, 8'hAE, 1, 0, 0, 1, 1, 0, 8'h00, 1));
        tbl[25] = V(0, 0, 8'h00, 1, 8'h40, E(8'h00, 8'hAE, 0, 1, 0, 1, 0, 0, 8'h40, 1));
        tbl[26] = V(0, 0, 8'h00, 1, 8'h40, E(8'h00, 8'hAE, 0, 1, 0, 1, 0, 0, 8'h00, 1));
        tbl[27] = V(0, 0, 8'h00, 0, 8'h00, E(8'h00, 8'hAE, 0, 0, 0, 1, 1, 1, 8'h00, 1));
        tbl[28] = V(0, 0, 8'h00, 1, 8'h00, E(8'h00, 8'hAE, 0, 0, 0, 1, 1, 0, 8'h00, 1));
        tbl[29] = V(0, 0, 8'h00, 0, 8'h00, E(8'h00, 8'hAF, 1, 0, 0, 1, 1, 0, 8'h00, 1));
        tbl[30] = V(0, 0, 8'h00, 1, 8'h00, E(8'h00, 8'hAF, 0, 1, 0, 1, 0, 0, 8'h00, 1));

        bus.write_strobe             = 1'b0;
        bus.address                  = 1'b0;
        bus.data_bus_in              = 8'h00;
        bus.interrupt_acknowledge_n  = 1'b1;
        bus.highest_level_in_service = 8'h00;
        @(posedge clock);
        #1;
        do_reset(1'b1, "reset_initial");

        // 8086 init, OCW decode, AEOI and spurious-level vectors.
        for (int i = 0; i < 31; i++) begin
            step(tbl[i].ws, tbl[i].a0, tbl[i].d, tbl[i].inta_n, tbl[i].hls);
            check($sformatf("vec%0d", i), tbl[i].want);
        end

        // 8080 three-pulse sequence: single, no IC4.
        do_reset(1'b1, "reset_8080");
        step(1, 0, 8'h12, 1, 8'h00); check("i80_icw1", E(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        step(1, 1, 8'h40, 1, 8'h00); check("i80_icw2", E(8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 1));
        step(0, 0, 8'h00, 0, 8'h01); check("i80_p1lo", E(8'h00, 8'hCD, 1, 0, 0, 0, 1, 1, 8'h00, 1));
        step(0, 0, 8'h00, 1, 8'h01); check("i80_p1hi", E(8'h00, 8'hCD, 0, 0, 0, 0, 1, 0, 8'h00, 1));
        step(0, 0, 8'h00, 0, 8'h01); check("i80_p2lo", E(8'h00, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 1));
        step(0, 0, 8'h00, 1, 8'h01); check("i80_p2hi", E(8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 1));
        step(0, 0, 8'h00, 0, 8'h01); check("i80_p3lo", E(8'h00, 8'h40, 1, 0, 0, 0, 1, 0, 8'h00, 1));
        step(0, 0, 8'h00, 1, 8'h01); check("i80_done", E(8'h00, 8'h40, 0, 1, 0, 0, 0, 0, 8'h00, 1));

        // ICW1 after pulse 1 aborts; the next sequence must start again at pulse 1.
        do_reset(1'b1, "reset_abort");
        step(1, 0, 8'h13, 1, 8'h00);
        step(1, 1, 8'h20, 1, 8'h00);
        step(1, 1, 8'h01, 1, 8'h00); check("ab_ready", E(8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 1));
        step(0, 0, 8'h00, 0, 8'h08); check("ab_p1", E(8'h00, 8'h00, 0, 0, 0, 0, 1, 1, 8'h00, 1));
        step(1, 0, 8'h13, 0, 8'h08); check("ab_icw1", E(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        step(0, 0, 8'h00, 1, 8'h08); check("ab_rise", E(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        step(1, 1, 8'h20, 1, 8'h08);
        step(1, 1, 8'h01, 1, 8'h08); check("ab_reinit", E(8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 1));
        step(0, 0, 8'h00, 0, 8'h08); check("ab_p1_again", E(8'h00, 8'h00, 0, 0, 0, 0, 1, 1, 8'h00, 1));
        step(0, 0, 8'h00, 1, 8'h08);
        step(0, 0, 8'h00, 0, 8'h08); check("ab_p2", E(8'h00, 8'h23, 1, 0, 0, 0, 1, 0, 8'h00, 1));

        // Reset in the middle of pulse 2.
        do_reset(1'b0, "reset_mid_inta");
        step(0, 0, 8'h00, 1, 8'h08); check("rst_after", 31'h0);

        // ICW1 on the same clock as an INTA falling edge wins.
        step(1, 0, 8'h13, 1, 8'h00);
        step(1, 1, 8'h20, 1, 8'h00);
        step(1, 1, 8'h01, 1, 8'h00); check("sim_ready", E(8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 1));
        step(1, 0, 8'h13, 0, 8'h08); check("sim_icw1_edge", E(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        step(0, 0, 8'h00, 1, 8'h08); check("sim_after", E(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
